// File: rtl/disc_writer_pkg.sv
// Shared definitions for the disc write sequencer: FSM state encoding and
// the timing-byte format constants used to decode the source FIFO stream.
package disc_writer_pkg;

    // Sequencer states. ST_WAIT_IDX is reached only in index-synchronised builds.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_IDX = 3'd1,
        ST_PRIME    = 3'd2,
        ST_RUN      = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Byte format of the timing stream.
    localparam logic [7:0] TERMINATOR    = 8'h00;
    localparam int         EXT_FLAG      = 7;
    localparam int         EXT_INCREMENT = 128;

    // An extension byte adds a fixed increment and produces no pulse.
    function automatic logic is_ext_byte(input logic [7:0] b);
        return b[EXT_FLAG];
    endfunction

endpackage

// File: rtl/disc_writer_idxsync.sv
// Index pulse synchroniser: two metastability flops, one history flop and a
// rising-edge detector. The single-clock pulse appears two clocks after the
// cycle in which index rises, so logic acting on it responds at the third edge.
module disc_writer_idxsync
    import disc_writer_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic index,
    output logic idx_pulse
);

    localparam int STAGES = 3;

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift chain: stage 0 samples the raw input, later stages follow.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_comb sync_d[gi] = index;
            end else begin : g_rest
                always_comb sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    // Synchroniser registers, cleared on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Rising edge of the synchronised index (stage 1 high, stage 2 still low).
    assign idx_pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/disc_writer.sv
// Disc write sequencer. Pops timing bytes from a FIFO, accumulates extension
// bytes, and emits write_data pulses spaced by the decoded intervals while
// write_gate is held. The next interval is prefetched during the current one.
// Build option: DISC_WRITER_INDEX_SYNC_EN -- wait for an index edge before
// writing and stop the write on the following index edge.
module disc_writer
    import disc_writer_pkg::*;
#(
    parameter int PULSE_WIDTH = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       index,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_rd,
    output logic       write_gate,
    output logic       write_data,
    output logic       busy,
    output logic       done,
    output logic       underflow
);

    localparam logic [4:0]             PW_LAST      = 5'(PULSE_WIDTH - 1);
    localparam logic [COUNT_WIDTH-1:0] MIN_INTERVAL = COUNT_WIDTH'(PULSE_WIDTH + 2);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX      = '1;

    state_t                  state_q, state_d;
    logic [COUNT_WIDTH-1:0]  acc_q, acc_d;
    logic [COUNT_WIDTH-1:0]  nxt_q, nxt_d;
    logic                    nxt_vld_q, nxt_vld_d;
    logic [COUNT_WIDTH-1:0]  elapsed_q, elapsed_d;
    logic                    rd_pend_q, rd_pend_d;
    logic                    term_q, term_d;
    logic                    underflow_q, underflow_d;
    logic                    write_gate_q, write_gate_d;
    logic                    write_data_q, write_data_d;
    logic [4:0]              pw_cnt_q, pw_cnt_d;

    logic                    active;
    logic                    byte_vld, byte_term, byte_ext, byte_time;
    logic                    need_byte, starve, fire, stop_req, idx_stop;
    logic                    start_ok, enter_prime;
    logic [7:0]              addend;
    logic [COUNT_WIDTH:0]    acc_sum;
    logic [COUNT_WIDTH-1:0]  acc_sat, interval;
    logic [COUNT_WIDTH:0]    elapsed_next;
    logic                    idx_pulse;

    disc_writer_idxsync u_idxsync (
        .clock     (clock),
        .reset     (reset),
        .index     (index),
        .idx_pulse (idx_pulse)
    );

`ifndef DISC_WRITER_INDEX_SYNC_EN
    // Index has no effect in this build.
    logic unused_idx_pulse;
    assign unused_idx_pulse = idx_pulse;
`endif

    // Decode the byte arriving from the FIFO and derive sequencing conditions.
    always_comb begin
        active       = (state_q == ST_PRIME) || (state_q == ST_RUN);
        byte_vld     = active && rd_pend_q;
        byte_term    = byte_vld && (fifo_data == TERMINATOR);
        byte_ext     = byte_vld && is_ext_byte(fifo_data);
        byte_time    = byte_vld && !byte_ext && !byte_term;
        need_byte    = active && !nxt_vld_q && !rd_pend_q && !term_q;
        starve       = need_byte && fifo_empty;
        elapsed_next = {1'b0, elapsed_q} + {{COUNT_WIDTH{1'b0}}, 1'b1};
        fire         = active && nxt_vld_q && !term_q && (elapsed_next >= {1'b0, nxt_q});
        stop_req     = term_q && !write_data_q;
        start_ok     = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start && !abort;
`ifdef DISC_WRITER_INDEX_SYNC_EN
        idx_stop     = (state_q == ST_RUN) && idx_pulse;
`else
        idx_stop     = 1'b0;
`endif
        // Saturating add of either the extension step or the timing count.
        addend   = byte_ext ? 8'(EXT_INCREMENT) : {1'b0, fifo_data[6:0]};
        acc_sum  = {1'b0, acc_q} + {{(COUNT_WIDTH-7){1'b0}}, addend};
        acc_sat  = acc_sum[COUNT_WIDTH] ? CNT_MAX : acc_sum[COUNT_WIDTH-1:0];
        interval = (acc_sat < MIN_INTERVAL) ? MIN_INTERVAL : acc_sat;
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
`ifdef DISC_WRITER_INDEX_SYNC_EN
                        state_d = ST_WAIT_IDX;
`else
                        state_d = ST_PRIME;
`endif
                    end
                end
`ifdef DISC_WRITER_INDEX_SYNC_EN
                ST_WAIT_IDX: begin
                    if (idx_pulse) begin
                        state_d = ST_PRIME;
                    end
                end
`endif
                ST_PRIME: begin
                    if (starve || stop_req) begin
                        state_d = ST_DONE;
                    end else if (byte_time) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (starve || stop_req) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from the current state and fetch condition.
    always_comb begin
        busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done    = (state_q == ST_DONE);
        fifo_rd = need_byte && !fifo_empty && !abort && !reset;
    end

    // Datapath next values: accumulator, prefetched interval, interval timer, pulse shaper.
    always_comb begin
        enter_prime  = (state_d == ST_PRIME) && (state_q != ST_PRIME);
        acc_d        = acc_q;
        nxt_d        = nxt_q;
        nxt_vld_d    = nxt_vld_q;
        elapsed_d    = elapsed_q;
        rd_pend_d    = fifo_rd;
        term_d       = term_q;
        underflow_d  = underflow_q;
        write_data_d = 1'b0;
        pw_cnt_d     = pw_cnt_q;

        if (start_ok) begin
            underflow_d = 1'b0;
        end

        if (enter_prime) begin
            // t0: the interval timer starts with the write gate.
            acc_d     = '0;
            nxt_vld_d = 1'b0;
            elapsed_d = '0;
            term_d    = 1'b0;
        end else if (active) begin
            elapsed_d = (elapsed_q == CNT_MAX) ? CNT_MAX : elapsed_next[COUNT_WIDTH-1:0];
            if (byte_ext) begin
                acc_d = acc_sat;
            end
            if (byte_time) begin
                nxt_d     = interval;
                nxt_vld_d = 1'b1;
                acc_d     = '0;
            end
            if (byte_term || idx_stop) begin
                term_d = 1'b1;
            end
            if (fire) begin
                nxt_vld_d = 1'b0;
                elapsed_d = '0;
            end
            if (starve) begin
                underflow_d = 1'b1;
            end
        end

        // Pulse shaper: hold write_data for PULSE_WIDTH clocks after each fire.
        if (write_data_q && (pw_cnt_q != 5'd0)) begin
            write_data_d = 1'b1;
            pw_cnt_d     = pw_cnt_q - 5'd1;
        end
        if (fire) begin
            write_data_d = 1'b1;
            pw_cnt_d     = PW_LAST;
        end

        // Drive signals are only ever high while a write is in progress.
        write_gate_d = (state_d == ST_PRIME) || (state_d == ST_RUN);
        if (!write_gate_d) begin
            write_data_d = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q        <= '0;
            nxt_q        <= '0;
            nxt_vld_q    <= 1'b0;
            elapsed_q    <= '0;
            rd_pend_q    <= 1'b0;
            term_q       <= 1'b0;
            underflow_q  <= 1'b0;
            write_gate_q <= 1'b0;
            write_data_q <= 1'b0;
            pw_cnt_q     <= '0;
        end else begin
            acc_q        <= acc_d;
            nxt_q        <= nxt_d;
            nxt_vld_q    <= nxt_vld_d;
            elapsed_q    <= elapsed_d;
            rd_pend_q    <= rd_pend_d;
            term_q       <= term_d;
            underflow_q  <= underflow_d;
            write_gate_q <= write_gate_d;
            write_data_q <= write_data_d;
            pw_cnt_q     <= pw_cnt_d;
        end
    end

    assign write_gate = write_gate_q;
    assign write_data = write_data_q;
    assign underflow  = underflow_q;

endmodule
